// File: rtl/change_dispenser_if.sv
// Bundles the dispenser's transaction, coin-handshake, status and refill signals.
// master = dispenser side, slave = controller/hopper side.
interface change_dispenser_if #(
  parameter int W     = 16,
  parameter int INV_W = 8
);
  logic               start;
  logic [W-1:0]       accumulator;
  logic [W-1:0]       item_val;
  logic               busy;
  logic               coin_valid;
  logic [1:0]         coin_sel;
  logic               coin_ready;
  logic               done;
  logic [1:0]         status;
  logic [W-1:0]       change;
  logic [W-1:0]       remaining;
  logic               refill_en;
  logic [1:0]         refill_sel;
  logic [INV_W-1:0]   refill_cnt;
  logic [4*INV_W-1:0] inv_count;

  modport master (
    input  start, accumulator, item_val, coin_ready, refill_en, refill_sel, refill_cnt,
    output busy, coin_valid, coin_sel, done, status, change, remaining, inv_count
  );

  modport slave (
    output start, accumulator, item_val, coin_ready, refill_en, refill_sel, refill_cnt,
    input  busy, coin_valid, coin_sel, done, status, change, remaining, inv_count
  );
endinterface

// File: rtl/change_dispenser.sv
// Computes change and pays it out greedily, one coin per valid/ready handshake.
// start->CHECK 1 cycle, first coin 2 cycles; a stalled coin holds coin_valid/coin_sel steady.
module change_dispenser #(
  parameter int W        = 16,
  parameter int D0       = 25,
  parameter int D1       = 10,
  parameter int D2       = 5,
  parameter int D3       = 1,
  parameter int INV_W    = 8,
  parameter int INV_INIT = 20
) (
  input logic                clk,
  input logic                rstn,
  change_dispenser_if.master bus
);

  typedef enum logic [1:0] {IDLE, CHECK, DISPENSE, DONE} state_t;

  localparam logic [INV_W-1:0] INV_RST = INV_W'(INV_INIT);

  state_t           state_q, state_d;
  logic [1:0]       status_q, status_d;
  logic [W-1:0]     change_q, change_d;
  logic [W-1:0]     remaining_q, remaining_d;
  logic [INV_W-1:0] inv_q [4];
  logic [INV_W-1:0] inv_d [4];
  logic [INV_W:0]   refill_sum;
  logic             sel_found;
  logic [1:0]       sel_idx;
  logic             coin_valid;

  function automatic logic [W-1:0] denom(input logic [1:0] k);
    case (k)
      2'd0:    denom = W'(D0);
      2'd1:    denom = W'(D1);
      2'd2:    denom = W'(D2);
      default: denom = W'(D3);
    endcase
  endfunction

  // Scan smallest to largest so the largest usable denomination wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (denom(2'(k)) <= remaining_q && inv_q[k] != '0) begin
        sel_found = 1'b1;
        sel_idx   = 2'(k);
      end
    end
  end

  assign coin_valid = (state_q == DISPENSE) && sel_found && (remaining_q != '0);

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    change_d    = change_q;
    remaining_d = remaining_q;
    refill_sum  = '0;
    for (int k = 0; k < 4; k++) inv_d[k] = inv_q[k];

    case (state_q)
      IDLE: begin
        if (bus.refill_en) begin
          refill_sum = {1'b0, inv_q[bus.refill_sel]} + {1'b0, bus.refill_cnt};
          inv_d[bus.refill_sel] = refill_sum[INV_W] ? '1 : refill_sum[INV_W-1:0];
        end
        if (bus.start) state_d = CHECK;
      end
      CHECK: begin
        if (bus.accumulator < bus.item_val) begin
          change_d    = '0;
          remaining_d = '0;
          status_d    = 2'b01;
          state_d     = DONE;
        end else begin
          change_d    = bus.accumulator - bus.item_val;
          remaining_d = bus.accumulator - bus.item_val;
          status_d    = 2'b00;
          state_d     = DISPENSE;
        end
      end
      DISPENSE: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end else if (!sel_found) begin
          status_d = 2'b10;
          state_d  = DONE;
        end else if (bus.coin_ready) begin
          remaining_d    = remaining_q - denom(sel_idx);
          inv_d[sel_idx] = inv_q[sel_idx] - INV_W'(1);
          // Leave straight after the final coin so done follows it by one cycle.
          if (remaining_d == '0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      status_q    <= 2'b00;
      change_q    <= '0;
      remaining_q <= '0;
      for (int k = 0; k < 4; k++) inv_q[k] <= INV_RST;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      change_q    <= change_d;
      remaining_q <= remaining_d;
      for (int k = 0; k < 4; k++) inv_q[k] <= inv_d[k];
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.coin_valid = coin_valid;
  assign bus.coin_sel   = coin_valid ? sel_idx : 2'd0;
  assign bus.done       = (state_q == DONE);
  assign bus.status     = status_q;
  assign bus.change     = change_q;
  assign bus.remaining  = remaining_q;
  assign bus.inv_count  = {inv_q[3], inv_q[2], inv_q[1], inv_q[0]};

endmodule
